// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Host-side bundle for the UART receive FIFO.
//   master : the producer/consumer side (receiver done tick + host reader)
//   slave  : the FIFO itself
//   Signals:
//     wr, w_data   - byte write strobe and data (from receiver)
//     rd           - read acknowledge, pops the head entry
//     clr_ovf      - clears the sticky overflow flag
//     r_data       - head entry (first-word-fall-through)
//     empty, full, almost_full, count, overflow - status
interface uart_rx_fifo_if #(
   parameter int unsigned DBIT   = 8,
   parameter int unsigned ADDR_W = 4
);
   logic              wr;
   logic [DBIT-1:0]   w_data;
   logic              rd;
   logic              clr_ovf;
   logic [DBIT-1:0]   r_data;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic [ADDR_W:0]   count;
   logic              overflow;

   modport master (
      output wr, w_data, rd, clr_ovf,
      input  r_data, empty, full, almost_full, count, overflow
   );

   modport slave (
      input  wr, w_data, rd, clr_ovf,
      output r_data, empty, full, almost_full, count, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side circular buffer behind the UART receiver. Each wr strobe
//   stores one byte; the head entry is always presented on r_data
//   (first-word-fall-through) and rd pops it. Flags and count are
//   registered from the next occupancy. A write while full without a
//   concurrent read is dropped and sets the sticky overflow flag.
//   Ports:
//     clk   - clock
//     reset - asynchronous, active-high reset (clears contents too)
//     bus   - uart_rx_fifo_if.slave (wr/w_data/rd/clr_ovf in, status out)
module uart_rx_fifo #(
   parameter int unsigned DBIT     = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic          clk,
   input  logic          reset,
   uart_rx_fifo_if.slave bus
);

   localparam int unsigned   DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);

   logic [DBIT-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wp;
   logic [ADDR_W-1:0] rp;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_next;
   logic              empty_q;
   logic              full_q;
   logic              af_q;
   logic              ovf_q;
   logic              ovf_next;
   logic              wr_ok;
   logic              rd_ok;

   // A write while full is still accepted when a read frees the head slot
   // in the same cycle; a read while empty never bypasses the new byte.
   assign wr_ok = bus.wr && (!full_q || bus.rd);
   assign rd_ok = bus.rd && !empty_q;

   always_comb begin
      count_next = count_q;
      unique case ({wr_ok, rd_ok})
         2'b10:   count_next = count_q + 1'b1;
         2'b01:   count_next = count_q - 1'b1;
         default: count_next = count_q;
      endcase
   end

   // Dropped write takes priority over a same-cycle clear.
   always_comb begin
      ovf_next = ovf_q;
      if (bus.wr && full_q && !bus.rd) begin
         ovf_next = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wp      <= '0;
         rp      <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem[wp] <= bus.w_data;
            wp      <= wp + 1'b1;
         end
         if (rd_ok) begin
            rp <= rp + 1'b1;
         end
         count_q <= count_next;
         empty_q <= (count_next == '0);
         full_q  <= (count_next == FULL_CNT);
         af_q    <= (count_next >= AF_CNT);
         ovf_q   <= ovf_next;
      end
   end

   assign bus.r_data      = mem[rp];
   assign bus.empty       = empty_q;
   assign bus.full        = full_q;
   assign bus.almost_full = af_q;
   assign bus.count       = count_q;
   assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo: a directed vector table for the
//   fill/drain/overflow sequence, hand-written wrap and mid-operation reset
//   sequences, then randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DBIT     = 8;
   localparam int ADDR_W   = 4;
   localparam int AF_LEVEL = 12;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus ();

   uart_rx_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests  = 0;
   int failed = 0;

   // reference model: plain queue of stored bytes plus the sticky flag
   logic [7:0] mq[$];
   bit         m_ovf;

   typedef struct {
      bit         wr;
      bit         rd;
      bit         clr;
      logic [7:0] d;
      int         cnt;
      bit         emp;
      bit         full;
      bit         af;
      bit         ovf;
      logic [7:0] rdat;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(bit wr, bit rd, bit clr, logic [7:0] d, int cnt,
                                   bit emp, bit full, bit af, bit ovf, logic [7:0] rdat);
      vec_t v;
      v.wr = wr; v.rd = rd; v.clr = clr; v.d = d; v.cnt = cnt;
      v.emp = emp; v.full = full; v.af = af; v.ovf = ovf; v.rdat = rdat;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit w, input bit r, input bit c, input logic [7:0] d);
      bit was_full;
      bit was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (r && !was_empty) void'(mq.pop_front());
      if (w && (!was_full || r)) mq.push_back(d);
      if (w && was_full && !r) m_ovf = 1'b1;
      else if (c)              m_ovf = 1'b0;
   endtask

   // drive one cycle's inputs, clock it, then advance the model
   task automatic cycle(input bit w, input bit r, input bit c, input logic [7:0] d);
      bus.wr = w; bus.rd = r; bus.clr_ovf = c; bus.w_data = d;
      @(posedge clk);
      #1;
      model_step(w, r, c, d);
      bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_ovf = 1'b0;
   endtask

   task automatic check_model();
      chk("count",       32'(bus.count),       32'(mq.size()));
      chk("empty",       32'(bus.empty),       32'(mq.size() == 0));
      chk("full",        32'(bus.full),        32'(mq.size() == DEPTH));
      chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= AF_LEVEL));
      chk("overflow",    32'(bus.overflow),    32'(m_ovf));
      if (mq.size() > 0) chk("r_data", 32'(bus.r_data), 32'(mq[0]));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_count"},    32'(bus.count),       32'd0);
      chk({tag, "_empty"},    32'(bus.empty),       32'd1);
      chk({tag, "_full"},     32'(bus.full),        32'd0);
      chk({tag, "_af"},       32'(bus.almost_full), 32'd0);
      chk({tag, "_overflow"}, 32'(bus.overflow),    32'd0);
      chk({tag, "_r_data"},   32'(bus.r_data),      32'd0);
   endtask

   initial begin
      bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_ovf = 1'b0; bus.w_data = '0;
      reset = 1'b1;
      m_ovf = 1'b0;

      // directed table: single write/read, fill, overflow, clear, full rd+wr, drain
      add_vec(1, 0, 0, 8'hA5, 1, 0, 0, 0, 0, 8'hA5);
      add_vec(0, 1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
      for (int i = 0; i < DEPTH; i++)
         add_vec(1, 0, 0, 8'(i), i + 1, 0, (i == DEPTH - 1), (i + 1 >= AF_LEVEL), 0, 8'h00);
      add_vec(1, 0, 0, 8'h77, 16, 0, 1, 1, 1, 8'h00);
      add_vec(1, 0, 1, 8'h88, 16, 0, 1, 1, 1, 8'h00);
      add_vec(0, 0, 1, 8'h00, 16, 0, 1, 1, 0, 8'h00);
      add_vec(1, 1, 0, 8'h55, 16, 0, 1, 1, 0, 8'h01);
      for (int k = 1; k <= DEPTH; k++)
         add_vec(0, 1, 0, 8'h00, DEPTH - k, (k == DEPTH), 0, (DEPTH - k >= AF_LEVEL), 0,
                 (k < 15) ? 8'(1 + k) : 8'h55);

      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[n]) begin
         cycle(vecs[n].wr, vecs[n].rd, vecs[n].clr, vecs[n].d);
         chk($sformatf("vec%0d_count", n),    32'(bus.count),       32'(vecs[n].cnt));
         chk($sformatf("vec%0d_empty", n),    32'(bus.empty),       32'(vecs[n].emp));
         chk($sformatf("vec%0d_full", n),     32'(bus.full),        32'(vecs[n].full));
         chk($sformatf("vec%0d_af", n),       32'(bus.almost_full), 32'(vecs[n].af));
         chk($sformatf("vec%0d_overflow", n), 32'(bus.overflow),    32'(vecs[n].ovf));
         if (!vecs[n].emp)
            chk($sformatf("vec%0d_r_data", n), 32'(bus.r_data), 32'(vecs[n].rdat));
      end

      // pointer wrap: 10 in, 10 out, 10 in (0x20..0x29), drain checking order
      for (int i = 0; i < 10; i++) begin cycle(1, 0, 0, 8'(8'h90 + i)); check_model(); end
      for (int i = 0; i < 10; i++) begin cycle(0, 1, 0, 8'h00); check_model(); end
      for (int i = 0; i < 10; i++) begin cycle(1, 0, 0, 8'(8'h20 + i)); check_model(); end
      for (int i = 0; i < 10; i++) begin
         chk("wrap_r_data", 32'(bus.r_data), 32'(8'h20 + i));
         cycle(0, 1, 0, 8'h00);
         check_model();
      end
      // read on empty: nothing changes
      cycle(0, 1, 0, 8'h00);
      check_model();
      // simultaneous rd+wr on empty: write only, no bypass
      cycle(1, 1, 0, 8'h6E);
      check_model();
      cycle(0, 1, 0, 8'h00);
      check_model();

      // mid-operation reset with overflow set and 5 entries stored
      for (int i = 0; i < DEPTH + 1; i++) cycle(1, 0, 0, 8'(8'h40 + i));
      for (int i = 0; i < 11; i++) cycle(0, 1, 0, 8'h00);
      check_model();
      reset = 1'b1;
      #1;
      check_reset_state("midreset");
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      cycle(1, 0, 0, 8'h3C);
      check_model();
      chk("post_reset_r_data", 32'(bus.r_data), 32'h3C);
      cycle(0, 1, 0, 8'h00);
      check_model();

      // randomized traffic, alternating fill-heavy and drain-heavy phases
      for (int n = 0; n < 2000; n++) begin
         int pw;
         int pr;
         pw = ((n / 200) % 2 == 0) ? 80 : 30;
         pr = ((n / 200) % 2 == 0) ? 30 : 75;
         cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
               $urandom_range(0, 99) < 8, 8'($urandom));
         check_model();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle done strobe and holds it in a circular buffer. Bytes are presented to the host side with first-word-fall-through semantics and a read-acknowledge handshake. Status flags, an occupancy count and a sticky overflow flag let the consumer drain at its own pace without losing framing of the byte stream.

## Interface
- DBIT, 8, data width; must equal receiver data width
- ADDR_W, 4, address width; depth = 2**ADDR_W (16)
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2**ADDR_W

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- wr  in  1  write strobe; connected to receiver done tick, one cycle per byte
- w_data  in  DBIT  byte to store, sampled when wr=1
- rd  in  1  read acknowledge; pops the head entry
- clr_ovf  in  1  clears the sticky overflow flag
- r_data  out  DBIT  head entry (first-word-fall-through)
- empty  out  1  no entries stored
- full  out  1  2**ADDR_W entries stored
- almost_full  out  1  count >= AF_LEVEL
- count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W
- overflow  out  1  sticky; set when a write is dropped

## Operation
- Storage: 2**ADDR_W x DBIT register array, write pointer wp and read pointer rp, each ADDR_W bits, wrapping modulo depth (15 -> 0).
- Reset (asynchronous): wp=rp=0, count=0, array cleared to 0, empty=1, full=0, almost_full=0, overflow=0, r_data=0.
- r_data = mem[rp] at all times; it is valid only while empty=0. While empty it shows the stale or reset slot content.
- Write accepted: wr=1 and (full=0 or rd=1). mem[wp] <= w_data, wp <= wp+1.
- Read accepted: rd=1 and empty=0. rp <= rp+1.
- Read on empty: ignored. Pointers, count and flags are unchanged, and no error is flagged.
- Write on full without rd: the byte is dropped, wp is unchanged, and overflow <= 1.
- Simultaneous rd and wr:
  - While empty, only the write occurs and count goes 0->1. The new byte is not bypassed to the reader that cycle.
  - While full, both the read and the write occur. Count stays at 2**ADDR_W and overflow is not set.
  - Otherwise both occur and count is unchanged.
- Count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Flags are registered and derived from next count: empty = (count==0), full = (count==2**ADDR_W), almost_full = (count>=AF_LEVEL).
- Overflow:
  - Set by a dropped write.
  - Cleared by clr_ovf=1.
  - If set and clear occur in the same cycle, set wins.
  - Overflow has no effect on the stored data.

## Timing
- Write-to-visible latency is 1 cycle. After the edge that accepts a write into an empty FIFO, empty=0 and r_data holds the byte in the following cycle.
- Read: when rd is sampled high at edge N, r_data shows the next entry after edge N, and the count/flags update at the same edge.
- All outputs change only on clk rising edges, or asynchronously on reset.
- The wr strobe is at most 1 cycle wide per byte (receiver guarantee). The block nevertheless treats back-to-back wr cycles as distinct writes.
- Reset mid-operation discards all contents immediately. The first write after reset deasserts lands at slot 0.

## Test plan
- Reset then single write (wr=1, w_data=0xA5) -> next cycle: empty=0, count=1, r_data=0xA5. Pulse rd -> empty=1, count=0.
- Fill 16 bytes 0x00..0x0F -> full=1, count=16, almost_full=1 (asserted from the 12th write on). Drain 16 reads -> r_data sequence 0x00..0x0F in order, then empty=1.
- Full FIFO, write 0x77 without rd -> overflow=1, count=16, and the contents still read 0x00..0x0F. Then clr_ovf=1 with a concurrent dropped write -> overflow stays 1. Then clr_ovf alone -> overflow=0.
- Full FIFO, rd=1 and wr=1 with w_data=0x55 -> count=16, overflow=0, and the last entry read out is 0x55.
- Pointer wrap: write 10, read 10, write 10 (0x20..0x29), read all -> 0x20..0x29 in order. Also rd on empty -> no change to count or flags.
- Assert reset with 5 entries stored -> empty=1, count=0, overflow=0, r_data=0 immediately. A subsequent write of 0x3C is read back as 0x3C.
